// File: rtl/param_ld_st_queue.sv
// param_ld_st_queue: in-order load/store queue with store-to-load forwarding and ID-matched cache responses
module param_ld_st_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int Z_W    = 4,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_rd,
  input  logic              enq_wr,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [CTRL_W-1:0] enq_ctrl,
  input  logic [Z_W-1:0]    enq_z,
  output logic              full,
  output logic              empty,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [Z_W-1:0]    out_z,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ID_W-1:0]   mem_id,
  input  logic              mem_stall,
  input  logic              mem_rvalid,
  input  logic [ID_W-1:0]   mem_rid,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [DEPTH-1:0]  v_q, v_d, st_q, st_d, isd_q, isd_d, dn_q, dn_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [Z_W-1:0]    z_q [DEPTH];
  logic [Z_W-1:0]    z_d [DEPTH];
  logic [ID_W-1:0]   hp_q, hp_d, ip_q, ip_d, tp_q, tp_d, fidx_q, fidx_d;
  logic [ID_W:0]     cnt_q, cnt_d, look;
  logic              full_q, empty_q, fwd_q, fwd_d;
  logic              out_valid_q, out_valid_d, mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, mem_wdata_q, mem_wdata_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [Z_W-1:0]    out_z_q, out_z_d;
  logic [ID_W-1:0]   mem_id_q, mem_id_d;
  logic              adv, ret, en, cand;

  // youngest valid store older than slot i (walking from head h) with the same address: {hit, index}
  function automatic logic [ID_W:0] fwd_lookup(input logic [DEPTH-1:0] v, input logic [DEPTH-1:0] st,
                                               input logic [ADDR_W-1:0] a [DEPTH],
                                               input logic [ID_W-1:0] h, input logic [ID_W-1:0] i);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] e;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      e = h + ID_W'(k);
      if (ID_W'(k) < ID_W'(i - h) && v[e] && st[e] && a[e] == a[i]) r = {1'b1, e};
    end
    return r;
  endfunction

  // next entry state from response, issue/forward, retire and enqueue; issue outputs precomputed from it
  always_comb begin
    v_d = v_q;
    st_d = st_q;
    isd_d = isd_q;
    dn_d = dn_q;
    addr_d = addr_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    z_d = z_q;
    adv = fwd_q | (mem_valid_q & ~mem_stall);
    ret = v_q[hp_q] & dn_q[hp_q];
    en = (enq_rd ^ enq_wr) & ~full_q;
    if (mem_rvalid && v_q[mem_rid] && isd_q[mem_rid] && !dn_q[mem_rid]) begin
      dn_d[mem_rid] = 1'b1;
      if (!st_q[mem_rid]) data_d[mem_rid] = mem_rdata;
    end
    if (adv) isd_d[ip_q] = 1'b1;
    if (fwd_q) begin
      dn_d[ip_q] = 1'b1;
      data_d[ip_q] = data_q[fidx_q];
    end
    if (ret) v_d[hp_q] = 1'b0;
    if (en) begin
      v_d[tp_q] = 1'b1;
      st_d[tp_q] = enq_wr;
      isd_d[tp_q] = 1'b0;
      dn_d[tp_q] = 1'b0;
      addr_d[tp_q] = enq_addr;
      data_d[tp_q] = enq_data;
      ctrl_d[tp_q] = enq_ctrl;
      z_d[tp_q] = enq_z;
    end
    hp_d = hp_q + ID_W'(ret);
    ip_d = ip_q + ID_W'(adv);
    tp_d = tp_q + ID_W'(en);
    cnt_d = cnt_q + (ID_W+1)'(en) - (ID_W+1)'(ret);
    look = fwd_lookup(v_d, st_d, addr_d, hp_d, ip_d);
    cand = v_d[ip_d] & ~isd_d[ip_d];
    fwd_d = cand & ~st_d[ip_d] & look[ID_W];
    fidx_d = look[ID_W-1:0];
    mem_valid_d = cand & ~fwd_d;
    mem_rw_d = st_d[ip_d];
    mem_addr_d = addr_d[ip_d];
    mem_wdata_d = data_d[ip_d];
    mem_id_d = ip_d;
    out_valid_d = ret;
    out_addr_d = ret ? addr_q[hp_q] : out_addr_q;
    out_data_d = ret ? data_q[hp_q] : out_data_q;
    out_ctrl_d = ret ? ctrl_q[hp_q] : out_ctrl_q;
    out_z_d = ret ? z_q[hp_q] : out_z_q;
  end

  // state and registered outputs; reset discards every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      st_q <= '0;
      isd_q <= '0;
      dn_q <= '0;
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
      ctrl_q <= '{default: '0};
      z_q <= '{default: '0};
      hp_q <= '0;
      ip_q <= '0;
      tp_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      fwd_q <= 1'b0;
      fidx_q <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_id_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_z_q <= '0;
    end else begin
      v_q <= v_d;
      st_q <= st_d;
      isd_q <= isd_d;
      dn_q <= dn_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      z_q <= z_d;
      hp_q <= hp_d;
      ip_q <= ip_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
      full_q <= cnt_d == (ID_W+1)'(DEPTH);
      empty_q <= cnt_d == '0;
      fwd_q <= fwd_d;
      fidx_q <= fidx_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_id_q <= mem_id_d;
      out_valid_q <= out_valid_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_z_q <= out_z_d;
    end
  end

  assign full = full_q;
  assign empty = empty_q;
  assign out_valid = out_valid_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_z = out_z_q;
  assign mem_valid = mem_valid_q;
  assign mem_rw = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_id = mem_id_q;
endmodule

// File: tb/tb_param_ld_st_queue.sv
// tb_param_ld_st_queue: randomized bench with a program-order memory model and a cache emulator
module tb_param_ld_st_queue;
  localparam int DEPTH = 4, ADDR_W = 32, DATA_W = 32, CTRL_W = 16, Z_W = 4, ID_W = 2;
  logic clk, rst, enq_rd, enq_wr, full, empty, out_valid, mem_valid, mem_rw, mem_stall, mem_rvalid;
  logic [ADDR_W-1:0] enq_addr, out_addr, mem_addr;
  logic [DATA_W-1:0] enq_data, out_data, mem_wdata, mem_rdata;
  logic [CTRL_W-1:0] enq_ctrl, out_ctrl;
  logic [Z_W-1:0] enq_z, out_z;
  logic [ID_W-1:0] mem_id, mem_rid;

  param_ld_st_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .Z_W(Z_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .enq_rd(enq_rd), .enq_wr(enq_wr), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_ctrl(enq_ctrl), .enq_z(enq_z), .full(full), .empty(empty), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .out_ctrl(out_ctrl), .out_z(out_z),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_id(mem_id),
    .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rid(mem_rid), .mem_rdata(mem_rdata));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {logic st; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic [CTRL_W-1:0] ctrl; logic [Z_W-1:0] z;} op_t;
  typedef struct {logic [ID_W-1:0] id; logic [DATA_W-1:0] data;} rsp_t;
  op_t exp_q[$];
  op_t ent[DEPTH];
  rsp_t pend[$];
  logic [DATA_W-1:0] cmem[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] pmem[logic [ADDR_W-1:0]];
  int cnt_m, tail_m, n_chk, n_fail, n_ret, n_rd_req, n_wr_req;
  bit auto_rsp, auto_stall, last_acc, seen_req, first_rw;
  logic [ID_W-1:0] first_id;
  logic [DEPTH-1:0] ids_seen;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [DATA_W-1:0] prog_rd(input logic [ADDR_W-1:0] a);
    return pmem.exists(a) ? pmem[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] cache_rd(input logic [ADDR_W-1:0] a);
    return cmem.exists(a) ? cmem[a] : init_val(a);
  endfunction

  // one clock: model enqueue and cache acceptance, step the edge, then check retires and flags
  task automatic tick();
    op_t o;
    rsp_t r;
    int j;
    last_acc = !rst && (enq_rd ^ enq_wr) && cnt_m < DEPTH;
    if (last_acc) begin
      o.st = enq_wr; o.addr = enq_addr; o.ctrl = enq_ctrl; o.z = enq_z;
      o.data = enq_wr ? enq_data : prog_rd(enq_addr);
      if (enq_wr) pmem[enq_addr] = enq_data;
      exp_q.push_back(o);
      ent[tail_m] = o;
      tail_m = (tail_m + 1) % DEPTH;
      cnt_m++;
    end
    if (!rst && mem_valid === 1'b1 && mem_stall === 1'b0) begin
      n_chk++;
      if (mem_addr !== ent[mem_id].addr || mem_rw !== ent[mem_id].st || (mem_rw && mem_wdata !== ent[mem_id].data)) begin
        n_fail++;
        $display("FAIL mem_req id=%0d: got addr=%h rw=%b wdata=%h, expected addr=%h rw=%b wdata=%h",
                 mem_id, mem_addr, mem_rw, mem_wdata, ent[mem_id].addr, ent[mem_id].st, ent[mem_id].data);
      end
      if (!seen_req) begin seen_req = 1; first_id = mem_id; first_rw = mem_rw; end
      ids_seen[mem_id] = 1'b1;
      if (mem_rw) begin cmem[mem_addr] = mem_wdata; n_wr_req++; end else n_rd_req++;
      r.id = mem_id;
      r.data = mem_rw ? '0 : cache_rd(mem_addr);
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    enq_rd = 0; enq_wr = 0; mem_rvalid = 0;
    if (out_valid === 1'b1) begin
      n_chk++; n_ret++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got z=%h data=%h, expected no retire", out_z, out_data);
      end else begin
        o = exp_q.pop_front();
        cnt_m--;
        if (out_addr !== o.addr || out_data !== o.data || out_ctrl !== o.ctrl || out_z !== o.z) begin
          n_fail++;
          $display("FAIL retire: got addr=%h data=%h ctrl=%h z=%h, expected addr=%h data=%h ctrl=%h z=%h",
                   out_addr, out_data, out_ctrl, out_z, o.addr, o.data, o.ctrl, o.z);
        end
      end
    end
    n_chk++;
    if (full !== (cnt_m == DEPTH) || empty !== (cnt_m == 0)) begin
      n_fail++;
      $display("FAIL flags: got full=%b empty=%b, expected full=%b empty=%b", full, empty, cnt_m == DEPTH, cnt_m == 0);
    end
    if (auto_stall) mem_stall = ($urandom_range(0, 3) == 0);
    if (auto_rsp && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      j = $urandom_range(0, pend.size() - 1);
      mem_rvalid = 1; mem_rid = pend[j].id; mem_rdata = pend[j].data;
      pend.delete(j);
    end
  endtask

  task automatic apply_reset();
    rst = 1; enq_rd = 0; enq_wr = 0; mem_rvalid = 0; mem_stall = 0;
    auto_rsp = 0; auto_stall = 0;
    exp_q.delete(); pend.delete();
    cnt_m = 0; tail_m = 0; pmem = cmem;
    tick();
    rst = 0;
  endtask

  task automatic enq(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [Z_W-1:0] z);
    enq_rd = !wr; enq_wr = wr; enq_addr = a; enq_data = d; enq_ctrl = CTRL_W'($urandom); enq_z = z;
    tick();
  endtask

  task automatic respond(input logic [ID_W-1:0] id, input string name);
    int j;
    j = -1;
    foreach (pend[k]) if (pend[k].id == id) j = k;
    n_chk++;
    if (j < 0) begin
      n_fail++;
      $display("FAIL %s: no request seen for id=%0d, expected one", name, id);
      tick();
    end else begin
      mem_rvalid = 1; mem_rid = id; mem_rdata = pend[j].data;
      pend.delete(j);
      tick();
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c;
    c = 0;
    auto_rsp = 1;
    while ((exp_q.size() != 0 || pend.size() != 0) && c < budget) begin tick(); c++; end
    tick(); tick();
    n_chk++;
    if (c >= budget || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got empty=%b outstanding=%0d after %0d cycles, expected empty=1 outstanding=0", name, empty, exp_q.size(), c);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (empty !== 1 || full !== 0 || out_valid !== 0 || mem_valid !== 0 || out_addr !== 0 || out_data !== 0 ||
        out_ctrl !== 0 || out_z !== 0 || mem_rw !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_id !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: got empty=%b full=%b out_valid=%b mem_valid=%b out_data=%h mem_addr=%h, expected 1 0 0 0 0 0",
               empty, full, out_valid, mem_valid, out_data, mem_addr);
    end
  endtask

  task automatic test_forward();
    int base;
    apply_reset();
    seen_req = 0; n_rd_req = 0; n_wr_req = 0; base = n_ret; auto_rsp = 1;
    enq(1, 40, 9000, 4);
    enq(0, 40, 0, 8);
    wait_drain(100, "fwd_drain");
    n_chk++;
    if (n_rd_req != 0 || n_wr_req != 1 || first_rw != 1 || first_id !== 0) begin
      n_fail++;
      $display("FAIL fwd_requests: got reads=%0d writes=%0d first_rw=%b first_id=%0d, expected 0 1 1 0", n_rd_req, n_wr_req, first_rw, first_id);
    end
    n_chk++;
    if (n_ret - base != 2) begin
      n_fail++;
      $display("FAIL fwd_retires: got %0d, expected 2", n_ret - base);
    end
  endtask

  task automatic test_ooo_response();
    int base;
    apply_reset();
    cmem[44] = 5; cmem[48] = 7; pmem[44] = 5; pmem[48] = 7;
    base = n_ret;
    enq(0, 44, 0, 1);
    enq(0, 48, 0, 2);
    tick();
    respond(1, "ooo_rsp_id1");
    tick(); tick();
    n_chk++;
    if (n_ret != base) begin
      n_fail++;
      $display("FAIL ooo_hold: got %0d retires before head response, expected 0", n_ret - base);
    end
    respond(0, "ooo_rsp_id0");
    wait_drain(50, "ooo_drain");
    n_chk++;
    if (n_ret - base != 2) begin
      n_fail++;
      $display("FAIL ooo_retires: got %0d, expected 2", n_ret - base);
    end
  endtask

  task automatic test_full_stall();
    int base;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] w0;
    logic [ID_W-1:0] i0;
    logic r0;
    apply_reset();
    base = n_ret;
    mem_stall = 1;
    enq(1'($urandom_range(0, 1)), 32'h200 + 4 * $urandom_range(0, 3), DATA_W'($urandom), 0);
    a0 = mem_addr; w0 = mem_wdata; i0 = mem_id; r0 = mem_rw;
    n_chk++;
    if (mem_valid !== 1 || mem_id !== 0 || a0 !== ent[0].addr) begin
      n_fail++;
      $display("FAIL stall_first_req: got valid=%b id=%0d addr=%h, expected 1 0 %h", mem_valid, mem_id, a0, ent[0].addr);
    end
    for (int i = 1; i < DEPTH + 3; i++) begin
      if (i <= DEPTH) enq(1'($urandom_range(0, 1)), 32'h200 + 4 * $urandom_range(0, 3), DATA_W'($urandom), Z_W'(i));
      else tick();
      n_chk++;
      if (mem_valid !== 1 || mem_addr !== a0 || mem_wdata !== w0 || mem_id !== i0 || mem_rw !== r0) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b addr=%h id=%0d, expected 1 %h %0d", mem_valid, mem_addr, mem_id, a0, i0);
      end
    end
    n_chk++;
    if (full !== 1) begin
      n_fail++;
      $display("FAIL stall_full: got full=%b, expected 1", full);
    end
    mem_stall = 0;
    wait_drain(200, "stall_drain");
    n_chk++;
    if (n_ret - base != DEPTH) begin
      n_fail++;
      $display("FAIL stall_retires: got %0d, expected %0d", n_ret - base, DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    int base, ops;
    base = n_ret; ops = 0; ids_seen = '0;
    auto_rsp = 1; auto_stall = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      for (int w = 0; w < 50 && cnt_m == DEPTH; w++) tick();
      enq(1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 2), DATA_W'($urandom), Z_W'(i));
      if (last_acc) ops++;
      if ($urandom_range(0, 2) == 0) tick();
    end
    wait_drain(400, "b2b_drain");
    auto_stall = 0; mem_stall = 0;
    n_chk++;
    if (n_ret - base != ops) begin
      n_fail++;
      $display("FAIL b2b_retires: got %0d, expected %0d", n_ret - base, ops);
    end
    n_chk++;
    if (ids_seen !== '1) begin
      n_fail++;
      $display("FAIL b2b_ids: got ids seen=%b, expected all ones", ids_seen);
    end
  endtask

  task automatic test_stray();
    int base;
    apply_reset();
    base = n_ret;
    mem_stall = 1;
    enq(0, 32'h300, 0, 3);
    mem_rvalid = 1; mem_rid = 0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1; mem_rid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    n_chk++;
    if (n_ret != base) begin
      n_fail++;
      $display("FAIL stray_rsp: got %0d retires, expected 0", n_ret - base);
    end
    mem_stall = 0;
    wait_drain(50, "stray_drain");
    enq_rd = 1; enq_wr = 1; enq_addr = 32'h304; enq_z = 5;
    tick(); tick();
    n_chk++;
    if (empty !== 1 || mem_valid !== 0) begin
      n_fail++;
      $display("FAIL rd_wr_both: got empty=%b mem_valid=%b, expected 1 0", empty, mem_valid);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    rsp_t late;
    apply_reset();
    enq(0, 32'h400, 0, 1);
    enq(0, 32'h404, 0, 2);
    enq(1, 32'h408, 32'h1234, 3);
    tick();
    n_chk++;
    if (pend.size() != 3) begin
      n_fail++;
      $display("FAIL midrst_inflight: got %0d requests, expected 3", pend.size());
    end
    late.id = 0; late.data = 32'h5555;
    if (pend.size() > 0) late = pend[0];
    apply_reset();
    base = n_ret;
    n_chk++;
    if (empty !== 1 || mem_valid !== 0 || out_valid !== 0 || full !== 0) begin
      n_fail++;
      $display("FAIL midrst_state: got empty=%b mem_valid=%b out_valid=%b full=%b, expected 1 0 0 0", empty, mem_valid, out_valid, full);
    end
    mem_rvalid = 1; mem_rid = late.id; mem_rdata = late.data;
    tick(); tick(); tick();
    n_chk++;
    if (n_ret != base || empty !== 1) begin
      n_fail++;
      $display("FAIL midrst_late_rsp: got retires=%0d empty=%b, expected 0 1", n_ret - base, empty);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; enq_rd = 0; enq_wr = 0; enq_addr = 0; enq_data = 0; enq_ctrl = 0; enq_z = 0;
    mem_stall = 0; mem_rvalid = 0; mem_rid = 0; mem_rdata = 0;
    n_chk = 0; n_fail = 0; n_ret = 0; n_rd_req = 0; n_wr_req = 0; cnt_m = 0; tail_m = 0;
    auto_rsp = 0; auto_stall = 0; seen_req = 0; first_rw = 0; first_id = 0; ids_seen = '0;
    test_reset();
    test_forward();
    test_ooo_response();
    test_full_stall();
    test_back_to_back();
    test_stray();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
